// File: rtl/exc_cp0_if.sv
// MEM-stage to CP0 exception/interrupt bus: instruction status in, redirect and mfc0 data out.
interface exc_cp0_if;
    localparam int unsigned EXC_TYPE_W = 2;
    localparam int unsigned XLEN       = 32;

    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic                  in_slot;
    logic [EXC_TYPE_W-1:0] exc_type;
    logic                  trap;
    logic [5:0]            hw_int;
    logic                  cp0_write;
    logic [4:0]            cp0_waddr;
    logic [XLEN-1:0]       cp0_wdata;
    logic [4:0]            cp0_raddr;
    logic [XLEN-1:0]       cp0_rdata;
    logic                  int_signal;
    logic                  eret_signal;
    logic [XLEN-1:0]       target_pc;

    modport master (
        output valid, pc, in_slot, exc_type, trap, hw_int,
               cp0_write, cp0_waddr, cp0_wdata, cp0_raddr,
        input  cp0_rdata, int_signal, eret_signal, target_pc
    );

    modport slave (
        input  valid, pc, in_slot, exc_type, trap, hw_int,
               cp0_write, cp0_waddr, cp0_wdata, cp0_raddr,
        output cp0_rdata, int_signal, eret_signal, target_pc
    );
endinterface

// File: rtl/exc_cp0.sv
// Coprocessor 0: Count/Compare timer, Status/Cause/EPC, exception priority and redirect.
module exc_cp0 (
    input  logic      clk,
    input  logic      rst,
    exc_cp0_if.slave  cp0_if
);
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    localparam logic [1:0] EXC_SYS  = 2'd1;
    localparam logic [1:0] EXC_ERET = 2'd2;
    localparam logic [1:0] EXC_RI   = 2'd3;

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_TRAP = 5'd13;

    localparam logic [0:0] USER    = 1'b0;
    localparam logic [0:0] HANDLER = 1'b1;

    localparam logic [31:0] EXC_VECTOR = 32'h0000_0800;

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] epc_q, epc_d;
    logic [7:0]  im_q, im_d;
    logic        ie_q, ie_d;
    logic [0:0]  state_q, state_d;
    logic        bd_q, bd_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exccode_q, exccode_d;
    logic        timer_q, timer_d;

    logic [7:0]  ip_c;
    logic        int_pend_c;
    logic        exc_take_c;
    logic        eret_take_c;
    logic [4:0]  exc_code_c;
    logic [31:0] status_c;
    logic [31:0] cause_c;
    logic [31:0] rdata_c;
    logic        impl_raddr_c;

    // Timer pending shares IP[7] with the top hardware line.
    assign ip_c       = {cp0_if.hw_int[5] | timer_q, cp0_if.hw_int[4:0], ip_sw_q};
    assign int_pend_c = ie_q & (state_q == USER) & (|(ip_c & im_q));

    assign exc_take_c = ~rst & cp0_if.valid &
                        (int_pend_c | (cp0_if.exc_type == EXC_RI) |
                         (cp0_if.exc_type == EXC_SYS) | cp0_if.trap);
    assign eret_take_c = ~rst & cp0_if.valid & (cp0_if.exc_type == EXC_ERET) & ~exc_take_c;

    always_comb begin
        exc_code_c = CODE_TRAP;
        if (int_pend_c)                       exc_code_c = CODE_INT;
        else if (cp0_if.exc_type == EXC_RI)   exc_code_c = CODE_RI;
        else if (cp0_if.exc_type == EXC_SYS)  exc_code_c = CODE_SYS;
    end

    assign status_c = {16'h0, im_q, 6'h0, state_q, ie_q};
    assign cause_c  = {bd_q, 15'h0, ip_c, 1'b0, exccode_q, 2'b00};

    // mfc0 read path with same-cycle mtc0 bypass on implemented registers.
    always_comb begin
        impl_raddr_c = 1'b1;
        case (cp0_if.cp0_raddr)
            REG_COUNT:   rdata_c = count_q;
            REG_COMPARE: rdata_c = compare_q;
            REG_STATUS:  rdata_c = status_c;
            REG_CAUSE:   rdata_c = cause_c;
            REG_EPC:     rdata_c = epc_q;
            default: begin
                rdata_c      = 32'h0;
                impl_raddr_c = 1'b0;
            end
        endcase
        if (cp0_if.cp0_write && impl_raddr_c && (cp0_if.cp0_waddr == cp0_if.cp0_raddr))
            rdata_c = cp0_if.cp0_wdata;
    end

    assign cp0_if.cp0_rdata   = rdata_c;
    assign cp0_if.int_signal  = exc_take_c;
    assign cp0_if.eret_signal = eret_take_c;
    assign cp0_if.target_pc   = exc_take_c  ? EXC_VECTOR :
                                eret_take_c ? epc_q      : 32'h0;

    // Next-state: timer, mtc0 (blocked by a taken exception), then exception/ERET.
    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        epc_d     = epc_q;
        im_d      = im_q;
        ie_d      = ie_q;
        state_d   = state_q;
        bd_d      = bd_q;
        ip_sw_d   = ip_sw_q;
        exccode_d = exccode_q;
        timer_d   = timer_q | (count_q == compare_q);

        if (cp0_if.cp0_write && !exc_take_c) begin
            case (cp0_if.cp0_waddr)
                REG_COUNT:   count_d = cp0_if.cp0_wdata;
                REG_COMPARE: begin
                    compare_d = cp0_if.cp0_wdata;
                    timer_d   = 1'b0;
                end
                REG_STATUS: begin
                    im_d    = cp0_if.cp0_wdata[15:8];
                    ie_d    = cp0_if.cp0_wdata[0];
                    state_d = cp0_if.cp0_wdata[1];
                end
                REG_CAUSE:   ip_sw_d = cp0_if.cp0_wdata[9:8];
                REG_EPC:     epc_d   = cp0_if.cp0_wdata;
                default: ;
            endcase
        end

        if (exc_take_c) begin
            exccode_d = exc_code_c;
            if (state_q == USER) begin
                epc_d   = cp0_if.in_slot ? (cp0_if.pc - 32'd4) : cp0_if.pc;
                bd_d    = cp0_if.in_slot;
                state_d = HANDLER;
            end
        end else if (eret_take_c) begin
            state_d = USER;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= 32'h0;
            compare_q <= 32'h0;
            epc_q     <= 32'h0;
            im_q      <= 8'h0;
            ie_q      <= 1'b0;
            state_q   <= USER;
            bd_q      <= 1'b0;
            ip_sw_q   <= 2'b00;
            exccode_q <= 5'h0;
            timer_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            epc_q     <= epc_d;
            im_q      <= im_d;
            ie_q      <= ie_d;
            state_q   <= state_d;
            bd_q      <= bd_d;
            ip_sw_q   <= ip_sw_d;
            exccode_q <= exccode_d;
            timer_q   <= timer_d;
        end
    end
endmodule

// File: tb/tb_exc_cp0.sv
// Directed self-checking bench for exc_cp0: exception entry, ERET, interrupts, timer, reset.
module tb_exc_cp0;
    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_STATUS  = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;

    localparam logic [1:0] T_DEFAULT = 2'd0;
    localparam logic [1:0] T_SYS     = 2'd1;
    localparam logic [1:0] T_ERET    = 2'd2;
    localparam logic [1:0] T_RI      = 2'd3;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    exc_cp0_if bus ();

    exc_cp0 dut (
        .clk    (clk),
        .rst    (rst),
        .cp0_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        bus.cp0_raddr = addr;
        #1;
        chk(tag, bus.cp0_rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        bus.cp0_write = 1'b1;
        bus.cp0_waddr = addr;
        bus.cp0_wdata = data;
        tick();
        bus.cp0_write = 1'b0;
    endtask

    task automatic idle();
        bus.valid     = 1'b0;
        bus.trap      = 1'b0;
        bus.exc_type  = T_DEFAULT;
        bus.in_slot   = 1'b0;
        bus.cp0_write = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle();
        bus.pc        = 32'h0;
        bus.hw_int    = 6'h0;
        bus.cp0_waddr = 5'd0;
        bus.cp0_wdata = 32'h0;
        bus.cp0_raddr = 5'd0;

        // Reset: outputs gated even with an exception presented.
        bus.valid    = 1'b1;
        bus.exc_type = T_SYS;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_int", {31'h0, bus.int_signal}, 32'h0);
        chk("rst_eret", {31'h0, bus.eret_signal}, 32'h0);
        chk("rst_target", bus.target_pc, 32'h0);
        chk_reg("rst_epc", A_EPC, 32'h0);
        chk_reg("rst_status", A_STATUS, 32'h0);
        idle();
        rst = 1'b0;

        // Park Compare far away so the timer stays quiet.
        mtc0(A_COMPARE, 32'hFFFF_0000);

        // SYS
        bus.valid = 1'b1; bus.exc_type = T_SYS; bus.pc = 32'h100; bus.in_slot = 1'b0;
        #1;
        chk("sys_int", {31'h0, bus.int_signal}, 32'h1);
        chk("sys_target", bus.target_pc, 32'h800);
        tick();
        idle();
        chk_reg("sys_epc", A_EPC, 32'h100);
        chk_reg("sys_cause", A_CAUSE, 32'h0000_0020);
        chk_reg("sys_status", A_STATUS, 32'h0000_0002);

        // ERET with a same-cycle EPC write: old EPC is the target.
        bus.valid = 1'b1; bus.exc_type = T_ERET;
        bus.cp0_write = 1'b1; bus.cp0_waddr = A_EPC; bus.cp0_wdata = 32'h300;
        #1;
        chk("eret_sig", {31'h0, bus.eret_signal}, 32'h1);
        chk("eret_int", {31'h0, bus.int_signal}, 32'h0);
        chk("eret_target", bus.target_pc, 32'h100);
        tick();
        idle();
        chk_reg("eret_status", A_STATUS, 32'h0);
        chk_reg("eret_epc_wr", A_EPC, 32'h300);

        // Delay-slot RI; a concurrent Status write must be dropped.
        bus.valid = 1'b1; bus.exc_type = T_RI; bus.pc = 32'h204; bus.in_slot = 1'b1;
        bus.cp0_write = 1'b1; bus.cp0_waddr = A_STATUS; bus.cp0_wdata = 32'h0000_FF01;
        #1;
        chk("ri_int", {31'h0, bus.int_signal}, 32'h1);
        tick();
        idle();
        chk_reg("ri_epc", A_EPC, 32'h200);
        chk_reg("ri_cause", A_CAUSE, 32'h8000_0028);
        chk_reg("ri_status", A_STATUS, 32'h0000_0002);

        // Trap while EXL=1: only ExcCode changes.
        bus.valid = 1'b1; bus.trap = 1'b1; bus.pc = 32'h400;
        #1;
        chk("trap_int", {31'h0, bus.int_signal}, 32'h1);
        chk("trap_target", bus.target_pc, 32'h800);
        tick();
        idle();
        chk_reg("trap_cause", A_CAUSE, 32'h8000_0034);
        chk_reg("trap_epc", A_EPC, 32'h200);

        bus.valid = 1'b1; bus.exc_type = T_ERET;
        #1;
        chk("eret2_target", bus.target_pc, 32'h200);
        tick();
        idle();
        chk_reg("eret2_status", A_STATUS, 32'h0);

        // Interrupt beats a simultaneous SYS.
        mtc0(A_STATUS, 32'h0000_0401);
        bus.hw_int = 6'h01;
        bus.valid = 1'b1; bus.exc_type = T_SYS; bus.pc = 32'h500;
        #1;
        chk("irq_int", {31'h0, bus.int_signal}, 32'h1);
        chk("irq_eret", {31'h0, bus.eret_signal}, 32'h0);
        tick();
        idle();
        chk_reg("irq_cause", A_CAUSE, 32'h0000_0400);
        chk_reg("irq_epc", A_EPC, 32'h500);
        chk_reg("irq_status", A_STATUS, 32'h0000_0403);
        bus.valid = 1'b1;
        #1;
        chk("irq_exl_masked", {31'h0, bus.int_signal}, 32'h0);
        idle();
        bus.hw_int = 6'h00;
        mtc0(A_STATUS, 32'h0);
        chk_reg("status_clr", A_STATUS, 32'h0);

        // Software IP bits, bypass and unimplemented read.
        mtc0(A_CAUSE, 32'hFFFF_FFFF);
        chk_reg("cause_sw", A_CAUSE, 32'h0000_0300);
        bus.cp0_write = 1'b1; bus.cp0_waddr = A_CAUSE; bus.cp0_wdata = 32'h1234_5678;
        chk_reg("bypass", A_CAUSE, 32'h1234_5678);
        tick();
        bus.cp0_write = 1'b0;
        chk_reg("cause_sw2", A_CAUSE, 32'h0000_0200);
        chk_reg("unimpl", 5'd3, 32'h0);

        // Count wrap.
        mtc0(A_COUNT, 32'hFFFF_FFFF);
        chk_reg("count_max", A_COUNT, 32'hFFFF_FFFF);
        tick();
        chk_reg("count_wrap", A_COUNT, 32'h0);

        // Reset mid-exception.
        tick();
        bus.valid = 1'b1; bus.exc_type = T_SYS; bus.pc = 32'h700;
        #1;
        chk("mid_int_pre", {31'h0, bus.int_signal}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_int", {31'h0, bus.int_signal}, 32'h0);
        chk("mid_target", bus.target_pc, 32'h0);
        chk("mid_eret", {31'h0, bus.eret_signal}, 32'h0);
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reg("mid_epc", A_EPC, 32'h0);
        chk_reg("mid_status", A_STATUS, 32'h0);

        // Timer: Compare=5 right after reset, IM7/IE enabled.
        mtc0(A_COMPARE, 32'h5);
        mtc0(A_STATUS, 32'h0000_8001);
        bus.valid = 1'b1; bus.pc = 32'h600;
        tick();
        chk("tmr_early", {31'h0, bus.int_signal}, 32'h0);
        tick();
        tick();
        chk_reg("tmr_count", A_COUNT, 32'h5);
        chk("tmr_eq_cycle", {31'h0, bus.int_signal}, 32'h0);
        tick();
        chk("tmr_int", {31'h0, bus.int_signal}, 32'h1);
        tick();
        idle();
        chk_reg("tmr_epc", A_EPC, 32'h600);
        chk_reg("tmr_cause", A_CAUSE, 32'h0000_8000);
        mtc0(A_COMPARE, 32'h100);
        chk_reg("tmr_clear", A_CAUSE, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exc_cp0.md
EXC_CP0 -- requirements
Module: exc_cp0

Interface
REQ-001 SHALL declare clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL declare rst  in  1  reset, asynchronous and active-high.
REQ-003 SHALL declare valid  in  1  MEM-stage instruction is real, not a bubble or flushed slot.
REQ-004 SHALL declare pc  in  32  MEM-stage instruction address.
REQ-005 SHALL declare in_slot  in  1  MEM-stage instruction sits in a branch delay slot.
REQ-006 SHALL declare exc_type  in  `EXC_TYPE_LENGTH  decoded exception class: DEFAULT, SYS, ERET or RI.
REQ-007 SHALL declare trap  in  1  ALU trap condition true (teq..tltiu family).
REQ-008 SHALL declare hw_int  in  6  external interrupt lines, level-sensitive.
REQ-009 SHALL declare cp0_write  in  1  mtc0 write enable.
REQ-010 SHALL declare cp0_waddr  in  5  write register number.
REQ-011 SHALL declare cp0_wdata  in  32  write data.
REQ-012 SHALL declare cp0_raddr  in  5  read register number.
REQ-013 SHALL declare cp0_rdata  out  32  read data, combinational.
REQ-014 SHALL declare int_signal  out  1  take exception/interrupt now; drives the decoder flush.
REQ-015 SHALL declare eret_signal  out  1  return from exception now.
REQ-016 SHALL declare target_pc  out  32  redirect address, valid while int_signal or eret_signal is high.

Function
REQ-017 SHALL implement Count(9), Compare(11), Status(12), Cause(13) and EPC(14); reads of any other register SHALL return 0.
REQ-018 Status SHALL use these fields: IM[15:8], EXL[1], IE[0]; all other bits read as 0.
REQ-019 Cause SHALL use these fields: BD[31], IP[15:8], ExcCode[6:2]; IP[7:2] = hw_int plus the timer bit, IP[1:0] software-writable; all other bits read as 0.
REQ-020 Count SHALL increment by 1 every cycle and wrap 0xFFFFFFFF->0.
REQ-021 When Count==Compare, the timer-pending bit SHALL set on the next edge; it feeds IP[7] and stays set until Compare is written.
REQ-022 int_pend = IE & ~EXL & |(IP & IM).
REQ-023 Priority within a cycle, all gated by valid: interrupt (ExcCode 0) > RI (10) > SYS (8) > trap (13) > ERET.
REQ-024 int_signal SHALL assert combinationally in the same cycle as any exception condition; target_pc = 32'h0000_0800.
REQ-025 On a taken exception with EXL=0, the next edge SHALL update the following:
- EPC = in_slot ? pc-4 : pc;
- BD = in_slot;
- ExcCode = the code of the taken exception;
- EXL = 1.
REQ-026 On a taken exception with EXL=1, the block SHALL update ExcCode only; EPC and BD SHALL hold, and the jump still occurs.
REQ-027 For ERET with no higher-priority event, eret_signal SHALL assert combinationally with target_pc = EPC; EXL SHALL clear on the next edge.
REQ-028 The block SHALL act as a two-state machine:
- USER (EXL=0) -> HANDLER on a taken exception;
- HANDLER -> USER on a taken ERET;
- a taken mtc0 write of Status.EXL also moves the state.
REQ-029 An mtc0 write SHALL update its target register on the next edge, except that the write is suppressed in any cycle where int_signal is high.
REQ-030 An mtc0 write to Cause SHALL affect IP[1:0] only.
REQ-031 A read of the same register in the same cycle as a write SHALL return cp0_wdata (bypass).
REQ-032 An ERET and an mtc0 write to EPC in the same cycle SHALL use the old EPC for target_pc.
REQ-033 int_signal and eret_signal SHALL never be high together.

Reset
REQ-034 On rst, asynchronously and regardless of clk, the block SHALL clear Count, Compare, Status, Cause, EPC and the timer-pending bit to 0, giving state USER.
REQ-035 During reset, int_signal, eret_signal and target_pc SHALL be 0.
REQ-036 A reset asserted mid-exception SHALL discard any pending register update.

Verification
REQ-037 Scenario SYS: valid=1, exc_type=SYS, pc=0x100, in_slot=0 -> int_signal=1 and target_pc=0x800 in the same cycle; next cycle EPC=0x100, ExcCode=8, EXL=1.
REQ-038 Scenario delay-slot RI: pc=0x204, in_slot=1, exc_type=RI -> EPC=0x200, BD=1, ExcCode=10.
REQ-039 Scenario ERET: EPC=0x100, exc_type=ERET -> eret_signal=1 and target_pc=0x100; EXL=0 next cycle; int_signal=0 throughout.
REQ-040 Scenario interrupt gating and priority: Status=0x0000_0401, hw_int[0]=1 -> interrupt (ExcCode 0) taken ahead of a simultaneous SYS; repeat with EXL=1 -> no interrupt.
REQ-041 Scenario timer: Compare=5 after reset, IM7=1, IE=1 -> interrupt within 2 cycles of Count==5; mtc0 to Compare clears IP[7].
REQ-042 Scenario reset mid-exception: rst asserted mid-cycle during int_signal -> outputs 0 immediately; EPC=0 and EXL=0 after release.
